// File: rtl/tl_lamp_if.sv
// La/Lb colour-code link between the traffic light controller and the lamp driver.
// The controller side drives codes and the fault clear; the driver side returns lamps and fault status.
interface tl_lamp_if;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       clr_fault;
  logic [3:0] lamp_a;
  logic [3:0] lamp_b;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output La, Lb, clr_fault,
    input  lamp_a, lamp_b, fault, fault_code
  );

  modport slave (
    input  La, Lb, clr_fault,
    output lamp_a, lamp_b, fault, fault_code
  );
endinterface

// File: rtl/tl_lamp_driver.sv
// Lamp driver for the left-turn traffic light: decodes La/Lb colour codes into lamp drives,
// watches the code stream for unsafe sequences and flashes red on both heads after a violation.
module tl_lamp_driver #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  tl_lamp_if.slave bus
);

  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned BW = $clog2(2 * BLINK_HALF);
  localparam logic [YW-1:0] Y_MIN      = YW'(MIN_YELLOW);
  localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    LEFT   = 2'b10,
    RED    = 2'b11
  } code_t;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_NORMAL = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    F_NONE      = 3'd0,
    F_CONFLICT  = 3'd1,
    F_ILLEGAL_A = 3'd2,
    F_ILLEGAL_B = 3'd3,
    F_SHORT_A   = 3'd4,
    F_SHORT_B   = 3'd5
  } fault_t;

  state_t        state, state_n;
  code_t         la_q, la_prev, lb_q, lb_prev;
  logic [YW-1:0] ycnt_a, ycnt_b;
  logic [BW-1:0] blink_cnt, blink_n, blink_inc;
  logic          init_cnt, init_n;
  logic [3:0]    lamp_a_r, lamp_b_r, lamp_a_n, lamp_b_n;
  fault_t        code_r, code_n, viol;
  logic          clr_y;
  logic          conflict, illegal_a, illegal_b, short_a, short_b, exit_ok;

  function automatic logic [3:0] decode(input code_t c);
    case (c)
      GREEN:   decode = 4'b0010;
      YELLOW:  decode = 4'b0100;
      LEFT:    decode = 4'b0001;
      default: decode = 4'b1000;
    endcase
  endfunction

  function automatic logic legal(input code_t p, input code_t q);
    legal = (p == q)
         || (p == GREEN  && q == YELLOW)
         || (p == YELLOW && q == LEFT)
         || (p == LEFT   && q == YELLOW)
         || (p == YELLOW && q == RED)
         || (p == RED    && q == GREEN);
  endfunction

  // Two-deep sampling pipeline; yellow counters track how long q has been YELLOW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      la_q    <= RED;
      la_prev <= RED;
      lb_q    <= RED;
      lb_prev <= RED;
      ycnt_a  <= '0;
      ycnt_b  <= '0;
    end else begin
      la_q    <= code_t'(bus.La);
      la_prev <= la_q;
      lb_q    <= code_t'(bus.Lb);
      lb_prev <= lb_q;
      if (clr_y || la_q != YELLOW) ycnt_a <= '0;
      else if (ycnt_a != Y_MIN)    ycnt_a <= ycnt_a + YW'(1);
      if (clr_y || lb_q != YELLOW) ycnt_b <= '0;
      else if (ycnt_b != Y_MIN)    ycnt_b <= ycnt_b + YW'(1);
    end
  end

  assign conflict  = (la_q != RED) && (lb_q != RED);
  assign illegal_a = !legal(la_prev, la_q);
  assign illegal_b = !legal(lb_prev, lb_q);
  assign short_a   = (la_prev == YELLOW) && (la_q != YELLOW) && (ycnt_a < Y_MIN);
  assign short_b   = (lb_prev == YELLOW) && (lb_q != YELLOW) && (ycnt_b < Y_MIN);
  assign exit_ok   = bus.clr_fault &&
                     ((la_q == GREEN && lb_q == RED) || (la_q == RED && lb_q == GREEN));

  always_comb begin
    viol = F_NONE;
    if (conflict)       viol = F_CONFLICT;
    else if (illegal_a) viol = F_ILLEGAL_A;
    else if (illegal_b) viol = F_ILLEGAL_B;
    else if (short_a)   viol = F_SHORT_A;
    else if (short_b)   viol = F_SHORT_B;
  end

  assign blink_inc = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);

  always_comb begin
    state_n  = state;
    init_n   = init_cnt;
    blink_n  = blink_cnt;
    lamp_a_n = lamp_a_r;
    lamp_b_n = lamp_b_r;
    code_n   = code_r;
    clr_y    = 1'b0;
    case (state)
      S_INIT: begin
        lamp_a_n = 4'b1000;
        lamp_b_n = 4'b1000;
        if (init_cnt) state_n = S_NORMAL;
        else          init_n  = 1'b1;
      end
      S_NORMAL: begin
        // A violating code is replaced by the first flash-on frame so it never reaches a lamp.
        if (viol != F_NONE) begin
          state_n  = S_FAULT;
          code_n   = viol;
          blink_n  = '0;
          lamp_a_n = 4'b1000;
          lamp_b_n = 4'b1000;
        end else begin
          lamp_a_n = decode(la_q);
          lamp_b_n = decode(lb_q);
        end
      end
      S_FAULT: begin
        if (exit_ok) begin
          state_n  = S_NORMAL;
          code_n   = F_NONE;
          clr_y    = 1'b1;
          lamp_a_n = decode(la_q);
          lamp_b_n = decode(lb_q);
        end else begin
          blink_n  = blink_inc;
          lamp_a_n = {(blink_inc < BLINK_ON), 3'b000};
          lamp_b_n = {(blink_inc < BLINK_ON), 3'b000};
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_cnt  <= 1'b0;
      blink_cnt <= '0;
      lamp_a_r  <= 4'b1000;
      lamp_b_r  <= 4'b1000;
      code_r    <= F_NONE;
    end else begin
      state     <= state_n;
      init_cnt  <= init_n;
      blink_cnt <= blink_n;
      lamp_a_r  <= lamp_a_n;
      lamp_b_r  <= lamp_b_n;
      code_r    <= code_n;
    end
  end

  assign bus.lamp_a     = lamp_a_r;
  assign bus.lamp_b     = lamp_b_r;
  assign bus.fault      = (state == S_FAULT);
  assign bus.fault_code = code_r;

endmodule

// File: tb/tb_tl_lamp_driver.sv
// Scoreboard bench for tl_lamp_driver: each stimulus step queues the outputs expected after its edge,
// and a negedge monitor pops and compares them.
module tb_tl_lamp_driver;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] LFT = 2'b10;
  localparam logic [1:0] RD  = 2'b11;

  logic clk = 1'b0;
  logic reset_n;

  tl_lamp_if bus ();

  tl_lamp_driver #(
    .MIN_YELLOW(3),
    .BLINK_HALF(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [1:0]  h1a, h1b, h2a, h2b;

  function automatic logic [3:0] dec(input logic [1:0] c);
    case (c)
      2'b00:   dec = 4'b0010;
      2'b01:   dec = 4'b0100;
      2'b10:   dec = 4'b0001;
      default: dec = 4'b1000;
    endcase
  endfunction

  // Monitor: outputs are presented every cycle; compare at the negedge after each queued edge.
  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] act;
    string       nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got a=%b b=%b fault=%b code=%0d, want a=%b b=%b fault=%b code=%0d",
                 nm, act[11:8], act[7:4], act[3], act[2:0], e[11:8], e[7:4], e[3], e[2:0]);
      end
    end
  end

  task automatic push(input logic [3:0] ea, input logic [3:0] eb, input logic ef,
                      input logic [2:0] ec, input string nm);
    exp_q.push_back({ea, eb, ef, ec});
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic clr,
                      input logic [3:0] ea, input logic [3:0] eb, input logic ef,
                      input logic [2:0] ec, input string nm);
    @(posedge clk);
    #1;
    push(ea, eb, ef, ec, nm);
    h2a = h1a;
    h2b = h1b;
    h1a = a;
    h1b = b;
    bus.La        = a;
    bus.Lb        = b;
    bus.clr_fault = clr;
  endtask

  // Legal traffic: lamps show the code driven two steps earlier.
  task automatic nstep(input logic [1:0] a, input logic [1:0] b, input logic clr, input string nm);
    step(a, b, clr, dec(h2a), dec(h2b), 1'b0, 3'd0, nm);
  endtask

  task automatic fstep(input logic [1:0] a, input logic [1:0] b, input logic clr,
                       input logic on, input logic [2:0] code, input string nm);
    step(a, b, clr, {on, 3'b000}, {on, 3'b000}, 1'b1, code, nm);
  endtask

  // Asserts reset right after an edge (async: visible before the next edge), then releases it.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push(4'b1000, 4'b1000, 1'b0, 3'd0, nm);
    bus.La = GRN; bus.Lb = RD; bus.clr_fault = 1'b0;
    h1a = GRN; h1b = RD; h2a = GRN; h2b = RD;
    @(posedge clk);
    #1;
    push(4'b1000, 4'b1000, 1'b0, 3'd0, "reset_hold");
    reset_n = 1'b1;
    step(GRN, RD, 1'b0, 4'b1000, 4'b1000, 1'b0, 3'd0, "init1");
    step(GRN, RD, 1'b0, 4'b1000, 4'b1000, 1'b0, 3'd0, "init2");
    nstep(GRN, RD, 1'b0, "init_exit");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.La        = GRN;
    bus.Lb        = RD;
    bus.clr_fault = 1'b0;
    h1a = GRN; h1b = RD; h2a = GRN; h2b = RD;

    // Reset release and INIT hold
    do_reset("reset");

    // Full legal A cycle, then B cycle
    for (int i = 0; i < 3; i++) nstep(YEL, RD, 1'b0, "a_yel1");
    for (int i = 0; i < 2; i++) nstep(LFT, RD, 1'b0, "a_left");
    for (int i = 0; i < 3; i++) nstep(YEL, RD, 1'b0, "a_yel2");
    nstep(RD, RD, 1'b0, "a_red");
    nstep(RD, GRN, 1'b0, "b_grn");
    for (int i = 0; i < 3; i++) nstep(RD, YEL, 1'b0, "b_yel1");
    for (int i = 0; i < 2; i++) nstep(RD, LFT, 1'b0, "b_left");
    for (int i = 0; i < 3; i++) nstep(RD, YEL, 1'b0, "b_yel2");
    nstep(RD, RD, 1'b0, "b_red");
    for (int i = 0; i < 3; i++) nstep(GRN, RD, 1'b0, "a_back_grn");

    // Short yellow A (2 cycles), then clear attempts
    nstep(YEL, RD, 1'b0, "sy_y1");
    nstep(YEL, RD, 1'b0, "sy_y2");
    nstep(LFT, RD, 1'b0, "sy_left");
    nstep(LFT, RD, 1'b0, "sy_left_hold");
    fstep(YEL, RD, 1'b1, 1'b1, 3'd4, "sy_fault");
    fstep(YEL, RD, 1'b1, 1'b1, 3'd4, "clr_ignored1");
    fstep(YEL, RD, 1'b1, 1'b1, 3'd4, "clr_ignored2");
    fstep(GRN, RD, 1'b1, 1'b1, 3'd4, "clr_ignored3");
    fstep(GRN, RD, 1'b1, 1'b0, 3'd4, "clr_ignored_off");
    step(GRN, RD, 1'b0, 4'b0010, 4'b1000, 1'b0, 3'd0, "clr_exit");
    nstep(GRN, RD, 1'b0, "after_exit");

    // Yellow held exactly MIN_YELLOW cycles: no fault
    for (int i = 0; i < 3; i++) nstep(YEL, RD, 1'b0, "y3_yel");
    nstep(LFT, RD, 1'b0, "y3_left");
    for (int i = 0; i < 3; i++) nstep(YEL, RD, 1'b0, "y3_yel2");
    nstep(RD, RD, 1'b0, "y3_red");
    for (int i = 0; i < 3; i++) nstep(GRN, RD, 1'b0, "y3_grn");

    // Conflict beats illegal A
    nstep(LFT, GRN, 1'b0, "cf_drive");
    nstep(LFT, GRN, 1'b0, "cf_hold");
    fstep(GRN, RD, 1'b1, 1'b1, 3'd1, "conflict");
    fstep(GRN, RD, 1'b1, 1'b1, 3'd1, "conflict_stay");
    step(GRN, RD, 1'b0, 4'b0010, 4'b1000, 1'b0, 3'd0, "conflict_clr");
    nstep(GRN, RD, 1'b0, "conflict_after");
    nstep(GRN, RD, 1'b0, "conflict_after2");

    // Illegal A (G->R), flash pattern, later violations and bad clears ignored, reset mid-flash
    nstep(RD, RD, 1'b0, "ill_drive");
    nstep(RD, RD, 1'b0, "ill_hold");
    fstep(GRN, GRN, 1'b0, 1'b1, 3'd2, "ill_fault");
    for (int i = 0; i < 3; i++) fstep(GRN, GRN, 1'b1, 1'b1, 3'd2, "flash_on1");
    for (int i = 0; i < 4; i++) fstep(GRN, GRN, 1'b0, 1'b0, 3'd2, "flash_off1");
    for (int i = 0; i < 4; i++) fstep(GRN, GRN, 1'b0, 1'b1, 3'd2, "flash_on2");
    fstep(GRN, GRN, 1'b0, 1'b0, 3'd2, "flash_off2");
    do_reset("reset_mid_flash");

    // clr_fault outside FAULT has no effect
    nstep(GRN, RD, 1'b1, "clr_normal1");
    nstep(GRN, RD, 1'b1, "clr_normal2");
    nstep(GRN, RD, 1'b0, "final");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
